// File: rtl/ste_pkg.sv
// Shared width helpers for the short-time-energy / VAD engine.
package ste_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned sq_w(input int unsigned data_width);
    return 2 * data_width;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned window_size);
    return clog2(window_size);
  endfunction

  function automatic int unsigned acc_w(input int unsigned data_width,
                                        input int unsigned window_size);
    return sq_w(data_width) + clog2(window_size);
  endfunction

  // Counter must hold HANGOVER itself; keep at least one bit for HANGOVER=0.
  function automatic int unsigned hang_w(input int unsigned hangover);
    int unsigned w;
    w = clog2(hangover + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/ste_square.sv
// One-stage registered signed squarer; valid follows the sample by one cycle.
module ste_square import ste_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                            i_clk,
  input  logic                            i_clear,
  input  logic [DATA_WIDTH-1:0]           i_data,
  input  logic                            i_valid,
  output logic [sq_w(DATA_WIDTH)-1:0]     o_sq,
  output logic                            o_valid
);

  localparam int unsigned SQ_W = sq_w(DATA_WIDTH);

  logic signed [SQ_W-1:0] w_ext;
  logic signed [SQ_W-1:0] w_prod;
  logic        [SQ_W-1:0] r_sq;
  logic                   r_valid;

  // Sign-extend first so the most-negative input squares without wrapping.
  assign w_ext  = {{DATA_WIDTH{i_data[DATA_WIDTH-1]}}, i_data};
  assign w_prod = w_ext * w_ext;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_sq    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) r_sq <= w_prod;
    end
  end

  assign o_sq    = r_sq;
  assign o_valid = r_valid;

endmodule

// File: rtl/ste_window_vad.sv
// Windowed short-time energy with threshold voice-activity detection and hangover.
module ste_window_vad import ste_pkg::*; #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned WINDOW_SIZE = 64,
  parameter int unsigned HANGOVER    = 3
) (
  input  logic                                       i_clk,
  input  logic                                       i_reset,
  input  logic [DATA_WIDTH-1:0]                      i_data,
  input  logic                                       i_data_valid,
  input  logic                                       i_flush,
  input  logic [acc_w(DATA_WIDTH, WINDOW_SIZE)-1:0]  i_threshold,
  output logic [acc_w(DATA_WIDTH, WINDOW_SIZE)-1:0]  o_ste,
  output logic                                       o_ste_valid,
  output logic                                       o_voice_active
);

  localparam int unsigned SQ_W   = sq_w(DATA_WIDTH);
  localparam int unsigned ACC_W  = acc_w(DATA_WIDTH, WINDOW_SIZE);
  localparam int unsigned CNT_W  = cnt_w(WINDOW_SIZE);
  localparam int unsigned HANG_W = hang_w(HANGOVER);

  logic [SQ_W-1:0]   w_sq;
  logic              w_sq_valid;
  logic [ACC_W-1:0]  w_energy;
  logic              w_last;

  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [HANG_W-1:0] r_hang;
  logic [ACC_W-1:0]  r_ste;
  logic              r_ste_valid;
  logic              r_voice;

  ste_square #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_square (
    .i_clk   (i_clk),
    .i_clear (i_reset | i_flush),
    .i_data  (i_data),
    .i_valid (i_data_valid),
    .o_sq    (w_sq),
    .o_valid (w_sq_valid)
  );

  assign w_energy = r_acc + ACC_W'(w_sq);
  assign w_last   = (r_cnt == CNT_W'(WINDOW_SIZE - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_hang      <= '0;
      r_ste       <= '0;
      r_ste_valid <= 1'b0;
      r_voice     <= 1'b0;
    end else begin
      r_ste_valid <= 1'b0;
      if (i_flush) begin
        // Aborted window: ste, VAD state and hang counter are left alone.
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_sq_valid) begin
        if (w_last) begin
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ste       <= w_energy;
          r_ste_valid <= 1'b1;
          if (w_energy > i_threshold) begin
            r_voice <= 1'b1;
            r_hang  <= HANG_W'(HANGOVER);
          end else if (r_hang == '0) begin
            r_voice <= 1'b0;
          end else begin
            r_hang <= r_hang - HANG_W'(1);
          end
        end else begin
          r_acc <= w_energy;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_ste          = r_ste;
  assign o_ste_valid    = r_ste_valid;
  assign o_voice_active = r_voice;

endmodule

// File: doc/ste_window_vad.md
Name: ste_window_vad

Overview:
- Parametrised short-time-energy (STE) engine for the I2S audio path.
- Takes a stream of signed PCM samples with a valid strobe and squares each sample at full precision.
- Accumulates the squares over a configurable window, then emits the window energy with a one-cycle valid pulse.
- Adds threshold-based voice-activity detection with a hangover, replacing the fixed-window, ROM-squared, free-running energy block.

Parameters:
- DATA_WIDTH, 16: sample width, two's complement.
- WINDOW_SIZE, 64: samples per window; legal values are 2 and up, not restricted to powers of two.
- HANGOVER, 3: number of consecutive below-threshold windows for which voice_active is held after the last above-threshold window.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data  in  DATA_WIDTH  signed sample.
- data_valid  in  1  data is accepted on any edge where this is high.
- flush  in  1  abort the current window and discard the partial sum.
- threshold  in  ACC_W  unsigned energy threshold; sampled at window completion.
- ste  out  ACC_W  energy of the last completed window; holds between windows.
- ste_valid  out  1  one-cycle pulse when ste updates.
- voice_active  out  1  VAD decision.

Behaviour:
- Widths:
  - SQ_W = 2*DATA_WIDTH.
  - CNT_W = clog2(WINDOW_SIZE).
  - ACC_W = SQ_W + clog2(WINDOW_SIZE).
  - The accumulator can never overflow; no saturation logic.
- Reset (synchronous): ste=0, ste_valid=0, voice_active=0. Internal accumulator, sample count, hang counter and square-valid stage are all cleared.
- Stage 1 (square):
  - On an edge with data_valid=1, the registered square data*data (unsigned, SQ_W bits) is written and sq_valid=1 for one cycle.
  - Most-negative input squares correctly: -32768 -> 2^30.
- Stage 2 (accumulate), on an edge with sq_valid=1:
  - If count < WINDOW_SIZE-1: acc += sq, count++.
  - If count == WINDOW_SIZE-1: ste <= acc+sq, ste_valid <= 1, acc <= 0, count <= 0.
- Latency:
  - If the last sample of a window is presented with data_valid high in cycle n, ste_valid is high in cycle n+2.
  - Windows are back-to-back and non-overlapping; throughput is one sample per clock.
  - Gaps in data_valid simply stall counting; partial sums are retained.
- VAD, evaluated in the same edge that loads ste, using the new window energy E:
  - If E > threshold: voice_active <= 1, hang <= HANGOVER.
  - Else if hang == 0: voice_active <= 0.
  - Else: hang <= hang-1, and voice_active holds.
  - The comparison is strict: E == threshold counts as below.
- flush:
  - Clears acc, count and the in-flight sq_valid on that edge.
  - No ste_valid is produced for the aborted window.
  - ste, voice_active and hang are unchanged.
  - flush and data_valid high on the same edge: flush wins and the sample is dropped.
  - flush in the same edge a window would complete: the window is aborted and no pulse is produced.
- Reset mid-window has the same effect as power-on reset: partial sums are lost and the next window starts on the next accepted sample.
- ste_valid is never high for two consecutive cycles when WINDOW_SIZE is 2 or more.

Decomposition:
- Package ste_pkg:
  - clog2 constant function.
  - Localparam derivation helpers for SQ_W, ACC_W and CNT_W.
  - VAD hang-counter width function: clog2(HANGOVER+1), minimum 1.
- Sub-module ste_square:
  - One-stage registered signed squarer with valid pass-through and sync clear (reset or flush).
  - Parametrised by DATA_WIDTH.
  - Replaces the external squares ROM.
- Top level holds the accumulator, window counter and VAD/hang logic.

Test Plan (all with DATA_WIDTH=16, WINDOW_SIZE=4, HANGOVER=2):
- Basic window: samples 1, 2, 3, 4 on consecutive cycles, threshold=100 -> ste=30 with ste_valid high 2 cycles after sample 4; voice_active stays 0.
- Extremes: four samples of -32768 -> ste=2^32 (34-bit, no wrap). Next window 32767 x4 -> ste=4294705156. Pulses are exactly 4 accepted samples apart.
- Gapped input: samples 1, 2, 3, 4 with data_valid low for 3 cycles between each sample -> ste=30. One pulse only, 2 cycles after the final sample.
- VAD hangover, threshold=100: window energies 400, 30, 30, 30 -> voice_active rises with the first pulse, stays 1 through the 2nd and 3rd pulses, and falls at the 4th. A window with E=100 exactly counts as below.
- Flush:
  - Samples 5, 5 then flush, then 1, 2, 3, 4 -> single ste=30; the 5s are discarded.
  - flush on the same edge as the 4th sample -> no pulse; ste keeps its prior value.
- Reset mid-window: 2 samples of 100, then reset high for 1 cycle, then samples 1, 2, 3, 4 -> ste=30, and voice_active is 0 after reset.
